fe_fetch_queue: RTL and testbench

Parametrised fetch front end that replaces the single-latch fetch stage. It holds the PC and reads the instruction memory every cycle. Fetched instructions are buffered in a QDEPTH-entry FIFO and handed to decode through a valid/ready handshake, so decode stalls no longer freeze the PC. The block sits between I-MEM and DE; AGEX redirects flush it, and an optional BTB predicts taken branches.

---
 rtl/fe_pkg.sv | 30 +++
 rtl/fe_btb.sv | 57 +++++
 rtl/fe_fetch_queue.sv | 153 +++++++++++++++
 tb/tb_fe_fetch_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fe_pkg.sv
// Shared types and constants for the fetch front end (fe_fetch_queue, fe_btb).
package fe_pkg;

   // Bytes per instruction; the sequential next PC is PC + INSTSIZE.
   localparam int INSTSIZE = 4;

   // PC loaded at reset unless the top overrides STARTPC.
   localparam logic [31:0] DEFAULT_STARTPC = 32'h0;

   // Queue entry at the default 32-bit widths. The top declares the same layout
   // sized by its own parameters.
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pcplus;
      logic        pred_taken;
      logic [31:0] pred_target;
   } fe_entry_t;

   // Ceiling log2 used to size pointers and indices (returns 0 for n <= 1).
   function automatic int fe_clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < n) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fe_btb.sv
// Direct-mapped branch target buffer: combinational lookup plus one update
// port written at the clock edge. A lookup in the same cycle as an update
// sees the old contents. Built only when FE_BTB_EN is defined.
module fe_btb
   import fe_pkg::*;
#(
   parameter int DBITS   = 32,
   parameter int ENTRIES = 16
) (
   input  logic             clk,
   input  logic             rst_ni,
   input  logic [DBITS-1:0] lookup_pc_i,
   output logic             hit_o,
   output logic [DBITS-1:0] target_o,
   input  logic             upd_valid_i,
   input  logic [DBITS-1:0] upd_pc_i,
   input  logic [DBITS-1:0] upd_target_i
);

   localparam int IDXW = fe_clog2(ENTRIES);
   localparam int TAGW = DBITS - IDXW - 2;

   logic             valid_q  [ENTRIES];
   logic [TAGW-1:0]  tag_q    [ENTRIES];
   logic [DBITS-1:0] target_q [ENTRIES];

   logic [IDXW-1:0] lookup_idx;
   logic [IDXW-1:0] upd_idx;

   // Byte-offset bits never select an entry or form part of the tag.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

   assign lookup_idx = lookup_pc_i[IDXW+1:2];
   assign upd_idx    = upd_pc_i[IDXW+1:2];

   assign hit_o    = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_pc_i[DBITS-1:IDXW+2]);
   assign target_o = target_q[lookup_idx];

   // Valid bits: cleared asynchronously on reset, set by an update.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end else if (upd_valid_i) begin
         valid_q[upd_idx] <= 1'b1;
      end
   end

   // Tag and target storage; contents are qualified by the valid bit.
   always_ff @(posedge clk) begin
      if (upd_valid_i) begin
         tag_q[upd_idx]    <= upd_pc_i[DBITS-1:IDXW+2];
         target_q[upd_idx] <= upd_target_i;
      end
   end

endmodule

// File: rtl/fe_fetch_queue.sv
// Fetch front end: PC register, combinational I-MEM read and a QDEPTH-entry
// FIFO feeding decode over valid/ready. AGEX redirects flush the queue and
// reload the PC. Define FE_BTB_EN to add a direct-mapped BTB (fe_btb) that
// steers the next PC on a hit; otherwise fetch is purely sequential.
module fe_fetch_queue
   import fe_pkg::*;
#(
   parameter int               DBITS        = 32,
   parameter int               INSTBITS     = 32,
   parameter int               IMEMADDRBITS = 16,
   parameter int               QDEPTH       = 4,
   parameter logic [DBITS-1:0] STARTPC      = DBITS'(DEFAULT_STARTPC),
   parameter int               BTB_ENTRIES  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic [IMEMADDRBITS-3:0] imem_addr,
   input  logic [INSTBITS-1:0]     imem_rdata,
   input  logic                    redirect_valid,
   input  logic [DBITS-1:0]        redirect_target,
   input  logic                    btb_upd_valid,
   input  logic [DBITS-1:0]        btb_upd_pc,
   input  logic [DBITS-1:0]        btb_upd_target,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [INSTBITS-1:0]     out_inst,
   output logic [DBITS-1:0]        out_pc,
   output logic [DBITS-1:0]        out_pcplus,
   output logic                    out_nonzero,
   output logic                    out_pred_taken,
   output logic [DBITS-1:0]        out_pred_target
);

   localparam int PTRW = fe_clog2(QDEPTH);
   localparam int CNTW = PTRW + 1;

   typedef struct packed {
      logic [INSTBITS-1:0] inst;
      logic [DBITS-1:0]    pc;
      logic [DBITS-1:0]    pcplus;
      logic                pred_taken;
      logic [DBITS-1:0]    pred_target;
   } entry_t;

   entry_t fifo_mem [QDEPTH];

   logic [DBITS-1:0] pc_q, pc_d;
   logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  count_q, count_d;

   logic             full, deq, fetch_en, enq;
   logic [DBITS-1:0] pc_plus4, next_pc;
   logic             pred_taken;
   logic [DBITS-1:0] pred_target;
   entry_t           new_entry, head;

   assign imem_addr = pc_q[IMEMADDRBITS-1:2];
   assign pc_plus4  = pc_q + DBITS'(INSTSIZE);

`ifdef FE_BTB_EN
   logic             btb_hit;
   logic [DBITS-1:0] btb_target;

   fe_btb #(
      .DBITS   (DBITS),
      .ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk          (clk),
      .rst_ni       (reset),
      .lookup_pc_i  (pc_q),
      .hit_o        (btb_hit),
      .target_o     (btb_target),
      .upd_valid_i  (btb_upd_valid),
      .upd_pc_i     (btb_upd_pc),
      .upd_target_i (btb_upd_target)
   );

   assign pred_taken  = btb_hit;
   assign pred_target = btb_hit ? btb_target : '0;
   assign next_pc     = btb_hit ? btb_target : pc_plus4;
`else
   // Without a BTB the update port has nothing to write.
   logic unused_btb_upd;
   assign unused_btb_upd = ^{btb_upd_valid, btb_upd_pc, btb_upd_target};

   assign pred_taken  = 1'b0;
   assign pred_target = '0;
   assign next_pc     = pc_plus4;
`endif

   // A dequeue frees a slot this cycle, so a full queue can still fetch when
   // decode takes the head; redirect discards the fetch.
   assign full      = (count_q == CNTW'(QDEPTH));
   assign out_valid = (count_q != '0);
   assign deq       = out_valid && out_ready;
   assign fetch_en  = !full || deq;
   assign enq       = fetch_en && !redirect_valid;

   assign new_entry = '{inst: imem_rdata, pc: pc_q, pcplus: pc_plus4,
                        pred_taken: pred_taken, pred_target: pred_target};

   // Head fields read zero whenever the queue is empty.
   assign head            = out_valid ? fifo_mem[rd_ptr_q] : '0;
   assign out_inst        = head.inst;
   assign out_pc          = head.pc;
   assign out_pcplus      = head.pcplus;
   assign out_nonzero     = |head.inst;
   assign out_pred_taken  = head.pred_taken;
   assign out_pred_target = head.pred_target;

   // Next-state for PC, pointers and count; redirect overrides fetch and dequeue.
   always_comb begin
      pc_d     = pc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (redirect_valid) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
         pc_d     = redirect_target;
      end else begin
         if (enq) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            pc_d     = next_pc;
         end
         if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
         if (enq && !deq)      count_d = count_q + 1'b1;
         else if (!enq && deq) count_d = count_q - 1'b1;
      end
   end

   // Control state, asynchronously returned to the reset values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= STARTPC;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Queue storage; stale slots are never visible because the head is masked.
   always_ff @(posedge clk) begin
      if (enq) fifo_mem[wr_ptr_q] <= new_entry;
   end

endmodule

// File: tb/tb_fe_fetch_queue.sv
// Randomized bench for fe_fetch_queue against a queue-based reference model.
// Works with or without FE_BTB_EN defined.
module tb_fe_fetch_queue;
   import fe_pkg::*;

   localparam int QD = 4;

   logic        clk;
   logic        reset;
   logic [13:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        btb_upd_valid;
   logic [31:0] btb_upd_pc;
   logic [31:0] btb_upd_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [31:0] out_pcplus;
   logic        out_nonzero;
   logic        out_pred_taken;
   logic [31:0] out_pred_target;

   fe_fetch_queue #(.QDEPTH(QD)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .btb_upd_valid   (btb_upd_valid),
      .btb_upd_pc      (btb_upd_pc),
      .btb_upd_target  (btb_upd_target),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_inst        (out_inst),
      .out_pc          (out_pc),
      .out_pcplus      (out_pcplus),
      .out_nonzero     (out_nonzero),
      .out_pred_taken  (out_pred_taken),
      .out_pred_target (out_pred_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: 64 words, mirrored across the address space.
   logic [31:0] imem [64];
   assign imem_rdata = imem[imem_addr[5:0]];

   // Reference model state.
   fe_entry_t   q[$];
   logic [31:0] pc_m;
   bit          btb_v   [16];
   logic [31:0] btb_pc  [16];
   logic [31:0] btb_tgt [16];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      pc_m = DEFAULT_STARTPC;
      for (int i = 0; i < 16; i++) btb_v[i] = 1'b0;
   endtask

   // One clock edge of the reference behaviour, using the inputs just applied.
   task automatic model_edge(input bit rdy, input bit rv, input logic [31:0] rt,
                             input bit uv, input logic [31:0] up, input logic [31:0] ut);
      bit          deq, full, fe, hit;
      logic [31:0] tgt;
      int          idx;
      fe_entry_t   e;
      deq  = (q.size() > 0) && rdy;
      full = (q.size() == QD);
      fe   = !full || deq;
      idx  = (pc_m >> 2) % 16;
      hit  = 1'b0;
      tgt  = 32'h0;
`ifdef FE_BTB_EN
      if (btb_v[idx] && ((btb_pc[idx] >> 6) == (pc_m >> 6))) begin
         hit = 1'b1;
         tgt = btb_tgt[idx];
      end
`endif
      if (rv) begin
         q.delete();
         pc_m = rt;
      end else begin
         if (deq) void'(q.pop_front());
         if (fe) begin
            e.inst        = imem[(pc_m >> 2) % 64];
            e.pc          = pc_m;
            e.pcplus      = pc_m + 32'd4;
            e.pred_taken  = hit;
            e.pred_target = tgt;
            q.push_back(e);
            pc_m = hit ? tgt : pc_m + 32'd4;
         end
      end
`ifdef FE_BTB_EN
      if (uv) begin
         btb_v[(up >> 2) % 16]   = 1'b1;
         btb_pc[(up >> 2) % 16]  = up;
         btb_tgt[(up >> 2) % 16] = ut;
      end
`else
      if (uv && (up == ut)) idx = 0;
`endif
   endtask

   task automatic check_outputs();
      fe_entry_t e;
      e = '0;
      if (q.size() > 0) e = q[0];
      chk("out_valid", out_valid, q.size() > 0);
      chk("out_inst", out_inst, e.inst);
      chk("out_pc", out_pc, e.pc);
      chk("out_pcplus", out_pcplus, e.pcplus);
      chk("out_nonzero", out_nonzero, |e.inst);
      chk("out_pred_taken", out_pred_taken, e.pred_taken);
      chk("out_pred_target", out_pred_target, e.pred_target);
      chk("imem_addr", imem_addr, pc_m[15:2]);
   endtask

   // Apply inputs at the falling edge, advance one clock, check at the next falling edge.
   task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rt,
                        input bit uv, input logic [31:0] up, input logic [31:0] ut);
      out_ready       = rdy;
      redirect_valid  = rv;
      redirect_target = rt;
      btb_upd_valid   = uv;
      btb_upd_pc      = up;
      btb_upd_target  = ut;
      @(posedge clk);
      model_edge(rdy, rv, rt, uv, up, ut);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle();
      out_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      btb_upd_valid = 1'b0; btb_upd_pc = '0; btb_upd_target = '0;
   endtask

   // Asynchronous reset between edges; released at a falling edge.
   task automatic async_reset();
      #2;
      reset = 1'b0;
      #1;
      chk("async_out_valid", out_valid, 1'b0);
      model_reset();
      check_outputs();
      idle();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_outputs();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) imem[i] = (i % 8 == 7) ? 32'h0 : $urandom;
      imem[0] = 32'h11; imem[1] = 32'h22; imem[2] = 32'h33;
      idle();
      reset = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("start_addr", imem_addr, 14'd0);

      // Streaming with decode always ready.
      cycle(1, 0, 0, 0, 0, 0);
      chk("seq0_pc", out_pc, 32'h0);
      chk("seq0_inst", out_inst, 32'h11);
      cycle(1, 0, 0, 0, 0, 0);
      chk("seq1_pc", out_pc, 32'h4);
      chk("seq1_inst", out_inst, 32'h22);
      cycle(1, 0, 0, 0, 0, 0);
      chk("seq2_pc", out_pc, 32'h8);
      chk("seq2_pcplus", out_pcplus, 32'hC);

      // Backpressure: queue fills with 0x0..0xC and the PC holds.
      @(negedge clk); reset = 1'b0; model_reset(); #1; reset = 1'b1; #1;
      for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, 0);
      chk("hold_addr", imem_addr, 14'd4);
      chk("hold_head_pc", out_pc, 32'h0);
      for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0, 0);

      // Redirect with three entries queued.
      async_reset();
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
      chk("pre_redir_valid", out_valid, 1'b1);
      cycle(1, 1, 32'h100, 0, 0, 0);
      chk("redir_valid", out_valid, 1'b0);
      cycle(0, 0, 0, 0, 0, 0);
      chk("redir_head_pc", out_pc, 32'h100);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0);

      // Reset while full.
      async_reset();
      cycle(0, 0, 0, 0, 0, 0);
      chk("post_reset_pc", out_pc, 32'h0);

      // BTB update 0x8 -> 0x40, then stream through 0x8.
      async_reset();
      cycle(1, 0, 0, 1, 32'h8, 32'h40);
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      chk("btb_head_pc", out_pc, 32'h8);
`ifdef FE_BTB_EN
      chk("btb_pred_taken", out_pred_taken, 1'b1);
      chk("btb_pred_target", out_pred_target, 32'h40);
      cycle(1, 0, 0, 0, 0, 0);
      chk("btb_next_pc", out_pc, 32'h40);
`else
      chk("btb_pred_taken", out_pred_taken, 1'b0);
      cycle(1, 0, 0, 0, 0, 0);
      chk("btb_next_pc", out_pc, 32'hC);
`endif

      // Random traffic: backpressure, redirects (some unaligned) and BTB updates.
      for (int i = 0; i < 400; i++) begin
         bit          rdy, rv, uv;
         logic [31:0] rt, up, ut;
         rdy = ($urandom_range(0, 9) < 7);
         rv  = ($urandom_range(0, 19) == 0);
         rt  = $urandom_range(0, 1023);
         if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
         uv  = ($urandom_range(0, 9) == 0);
         up  = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
         ut  = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
         cycle(rdy, rv, rt, uv, up, ut);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
